// File: rtl/vec_delta_accum.sv
// vec_delta_accum
//   Element-serial delta accumulator. It receives a stream of I-element delta
//   vectors in sign-magnitude form (bit N-1 = sign, bits N-2:0 = magnitude)
//   and adds each delta onto the stored reconstruction element at the current
//   index. The updated element is written back and emitted with one cycle of
//   latency.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   clear      in   1   zero every stored element and the index
//   in_valid   in   1   delta element valid
//   in_ready   out  1   delta element accepted this cycle when in_valid
//   in_delta   in   N   delta element, sign-magnitude
//   in_last    in   1   sender marks the final element of a vector
//   out_valid  out  1   reconstructed element valid
//   out_ready  in   1   downstream accepts the output
//   out_data   out  N   reconstructed element (never -0)
//   out_idx    out  IW  element index of out_data
//   out_last   out  1   out_idx == I-1
//   err_len    out  1   one-cycle pulse: in_last disagreed with the index
//
// Handshake: a beat moves on a port only on a rising edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// that edge, and in_ready never depends on in_valid.
module vec_delta_accum #(
    parameter  int I   = 20,
    parameter  int Q   = 15,
    parameter  int N   = 32,
    parameter  int SAT = 0,
    localparam int IW  = (I > 1) ? $clog2(I) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_delta,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          err_len
);

    // Q only names the fixed-point format; it must leave room for the sign.
    if (Q > N - 2) begin : g_bad_q
        $error("vec_delta_accum: Q must be at most N-2");
    end

    logic [N-1:0]  state_q [I];
    logic [IW-1:0] idx_q, idx_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          err_q, err_d;

    logic          accept;
    logic          last_idx;
    logic [N-2:0]  mag_a, mag_b, mag_r;
    logic          sgn_a, sgn_b, sgn_r;
    logic [N-1:0]  add_full;
    logic [N-1:0]  sum;

    assign last_idx = (idx_q == IW'(I - 1));
    assign in_ready = rst_n & ~clear & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Sign-magnitude add of the stored element and the incoming delta.
    // A negative zero operand has its sign dropped so it behaves as +0.
    always_comb begin
        mag_a    = state_q[idx_q][N-2:0];
        sgn_a    = state_q[idx_q][N-1] & (|mag_a);
        mag_b    = in_delta[N-2:0];
        sgn_b    = in_delta[N-1] & (|mag_b);
        add_full = {1'b0, mag_a} + {1'b0, mag_b};
        mag_r    = '0;
        sgn_r    = 1'b0;
        if (sgn_a == sgn_b) begin
            sgn_r = sgn_a;
            // add_full[N-1] is the carry out of the magnitude field.
            if (add_full[N-1] && (SAT != 0)) begin
                mag_r = '1;
            end else begin
                mag_r = add_full[N-2:0];
            end
        end else if (mag_a >= mag_b) begin
            sgn_r = sgn_a;
            mag_r = mag_a - mag_b;
        end else begin
            sgn_r = sgn_b;
            mag_r = mag_b - mag_a;
        end
        // A zero magnitude is always emitted as +0.
        sum = {sgn_r & (|mag_r), mag_r};
    end

    always_comb begin
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        // clear and accept never coincide because in_ready is low under clear.
        if (clear) begin
            idx_d = '0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_idx_d   = idx_q;
            out_last_d  = last_idx;
            err_d       = in_last ^ last_idx;
            // A misplaced in_last still resynchronises the index to 0.
            idx_d       = (in_last | last_idx) ? '0 : idx_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < I; i++) begin
                state_q[i] <= '0;
            end
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            if (clear) begin
                for (int i = 0; i < I; i++) begin
                    state_q[i] <= '0;
                end
            end else if (accept) begin
                state_q[idx_q] <= sum;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_vec_delta_accum.sv
module tb_vec_delta_accum;
    localparam int I = 20;
    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_delta = '0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, in_ready_s;
    logic          out_valid, out_valid_s;
    logic [N-1:0]  out_data, out_data_s;
    logic [4:0]    out_idx, out_idx_s;
    logic          out_last, out_last_s;
    logic          err_len, err_len_s;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    vec_delta_accum #(.I(I), .Q(15), .N(N), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_delta(in_delta), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .err_len(err_len)
    );

    vec_delta_accum #(.I(I), .Q(15), .N(N), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_delta(in_delta), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_idx(out_idx_s), .out_last(out_last_s), .err_len(err_len_s)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Values as signed integers: add, then fold back to sign-magnitude.
    function automatic logic [N-1:0] sm_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input bit sat);
        longint va, vb, s, mag;
        logic [63:0] m64;
        va = longint'(a[N-2:0]);
        if (a[N-1]) va = -va;
        vb = longint'(b[N-2:0]);
        if (b[N-1]) vb = -vb;
        s   = va + vb;
        mag = (s < 0) ? -s : s;
        if (mag > 64'h7FFF_FFFF) mag = sat ? 64'h7FFF_FFFF : (mag & 64'h7FFF_FFFF);
        m64 = 64'(mag);
        return {(s < 0) && (mag != 0), m64[30:0]};
    endfunction

    logic [N-1:0] m_st [I];
    logic [N-1:0] m_st_s [I];
    int           m_pos = 0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_data = '0, m_data_s = '0;
    int           m_oidx = 0;
    logic         m_last = 1'b0, m_err = 1'b0;
    bit           compare_en = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            for (int i = 0; i < I; i++) begin m_st[i] = '0; m_st_s[i] = '0; end
            m_pos = 0; m_valid = 0; m_data = '0; m_data_s = '0; m_oidx = 0; m_last = 0; m_err = 0;
        end else begin
            acc = in_valid && !clear && (!m_valid || out_ready);
            m_err = 1'b0;
            if (clear) begin
                for (int i = 0; i < I; i++) begin m_st[i] = '0; m_st_s[i] = '0; end
                m_pos = 0;
            end
            if (acc) begin
                m_st[m_pos]   = sm_model(m_st[m_pos], in_delta, 1'b0);
                m_st_s[m_pos] = sm_model(m_st_s[m_pos], in_delta, 1'b1);
                m_valid  = 1'b1;
                m_data   = m_st[m_pos];
                m_data_s = m_st_s[m_pos];
                m_oidx   = m_pos;
                m_last   = (m_pos == I - 1);
                m_err    = (in_last != (m_pos == I - 1));
                m_pos    = (in_last || m_pos == I - 1) ? 0 : m_pos + 1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (compare_en) begin
            check("in_ready", N'(in_ready), N'(rst_n && !clear && (!m_valid || out_ready)));
            check("in_ready_sat", N'(in_ready_s), N'(rst_n && !clear && (!m_valid || out_ready)));
            check("out_valid", N'(out_valid), N'(m_valid));
            check("out_valid_sat", N'(out_valid_s), N'(m_valid));
            check("err_len", N'(err_len), N'(m_err));
            check("err_len_sat", N'(err_len_s), N'(m_err));
            if (m_valid) begin
                check("out_data", out_data, m_data);
                check("out_data_sat", out_data_s, m_data_s);
                check("out_idx", N'(out_idx), N'(m_oidx));
                check("out_last", N'(out_last), N'(m_last));
            end
        end
    end

    // ---------------- capture of transferred beats ----------------
    logic [N-1:0] cap_d[$];
    logic [N-1:0] cap_s[$];
    logic [4:0]   cap_i[$];
    logic         cap_l[$];
    int           err_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_s.push_back(out_data_s);
            cap_i.push_back(out_idx);
            cap_l.push_back(out_last);
        end
        if (err_len) err_cnt++;
    end

    // ---------------- output backpressure ----------------
    int cyc_cnt = 0;
    int stall_from = -100;
    always @(posedge clk) begin
        cyc_cnt++;
        #1 out_ready = !(cyc_cnt >= stall_from && cyc_cnt < stall_from + 5);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N-1:0] d, input bit last);
        int cyc = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_delta = d;
        in_last  = last;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 200);
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [N-1:0] d);
        for (int k = 0; k < I; k++) send(d, k == I - 1);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic flush_cap();
        cap_d.delete(); cap_s.delete(); cap_i.delete(); cap_l.delete();
        err_cnt = 0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        check("clear_blocks_in_ready", N'(in_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Model pins.
        check("model_wrap", sm_model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0), 32'h0000_0000);
        check("model_sat", sm_model(32'h7FFF_FFFF, 32'h0000_0001, 1'b1), 32'h7FFF_FFFF);
        check("model_sub", sm_model(32'h0000_8000, 32'h8000_4000, 1'b0), 32'h0000_4000);
        check("model_zero", sm_model(32'h0000_4000, 32'h8000_4000, 1'b0), 32'h0000_0000);
        check("model_negzero", sm_model(32'h8000_0000, 32'h8000_0003, 1'b0), 32'h8000_0003);

        // Reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", N'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", N'(out_idx), 32'd0);
        check("rst_out_last", N'(out_last), 32'd0);
        check("rst_err_len", N'(err_len), 32'd0);
        rst_n = 1'b1;
        compare_en = 1'b1;

        // Vector of +1.0.
        flush_cap();
        send_vec(32'h0000_8000);
        drain();
        check("v1_count", N'(cap_d.size()), 32'd20);
        for (int k = 0; k < I && k < cap_d.size(); k++) begin
            check("v1_data", cap_d[k], 32'h0000_8000);
            check("v1_idx", N'(cap_i[k]), N'(k));
            check("v1_last", N'(cap_l[k]), N'(k == I - 1));
        end
        check("v1_err_none", N'(err_cnt), 32'd0);

        // Two vectors of -0.5.
        flush_cap();
        send_vec(32'h8000_4000);
        send_vec(32'h8000_4000);
        drain();
        check("v23_count", N'(cap_d.size()), 32'd40);
        for (int k = 0; k < 2 * I && k < cap_d.size(); k++)
            check("v23_data", cap_d[k], (k < I) ? 32'h0000_4000 : 32'h0000_0000);

        // Overflow of element 0.
        pulse_clear();
        flush_cap();
        send(32'h7FFF_FFFF, 1'b0);
        for (int k = 1; k < I; k++) send(32'h0, k == I - 1);
        send(32'h0000_0001, 1'b0);
        for (int k = 1; k < I; k++) send(32'h0, k == I - 1);
        drain();
        if (cap_d.size() >= I + 1) begin
            check("ovf_pre", cap_d[0], 32'h7FFF_FFFF);
            check("ovf_wrap", cap_d[I], 32'h0000_0000);
            check("ovf_sat", cap_s[I], 32'h7FFF_FFFF);
        end else begin
            check("ovf_count", N'(cap_d.size()), N'(2 * I));
        end

        // Output stall mid-stream.
        flush_cap();
        stall_from = cyc_cnt + 6;
        for (int k = 0; k < I; k++) send(32'h100 * (k + 1), k == I - 1);
        drain();
        check("bp_count", N'(cap_d.size()), 32'd20);
        for (int k = 0; k < I && k < cap_d.size(); k++) begin
            check("bp_idx", N'(cap_i[k]), N'(k));
            check("bp_data", cap_d[k], 32'h100 * (k + 1));
        end
        if (cap_s.size() > 0) check("bp_sat0", cap_s[0], 32'h7FFF_FFFF);

        // Early in_last on element 7.
        flush_cap();
        for (int k = 0; k < 8; k++) send(32'h1, k == 7);
        send(32'h1, 1'b0);
        drain();
        check("err_pulses", N'(err_cnt), 32'd1);
        if (cap_i.size() >= 9) begin
            check("err_idx7", N'(cap_i[7]), 32'd7);
            check("err_last7", N'(cap_l[7]), 32'd0);
            check("err_resync", N'(cap_i[8]), 32'd0);
        end else begin
            check("err_count", N'(cap_i.size()), 32'd9);
        end

        // Clear mid-vector.
        for (int k = 0; k < 3; k++) send(32'h0000_0005, 1'b0);
        pulse_clear();
        drain();
        flush_cap();
        send_vec(32'h0000_8000);
        drain();
        check("clr_count", N'(cap_d.size()), 32'd20);
        for (int k = 0; k < cap_d.size(); k++) begin
            check("clr_data", cap_d[k], 32'h0000_8000);
            check("clr_idx", N'(cap_i[k]), N'(k));
        end
        check("clr_err_none", N'(err_cnt), 32'd0);

        // Reset mid-vector with a pending output.
        out_ready_hold: begin
            stall_from = cyc_cnt + 1;
            for (int k = 0; k < 5; k++) send(32'h0000_8000, 1'b0);
            check("mid_pending", N'(out_valid), 32'd1);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            check("mrst_out_valid", N'(out_valid), 32'd0);
            check("mrst_out_data", out_data, 32'd0);
            check("mrst_out_idx", N'(out_idx), 32'd0);
            check("mrst_out_last", N'(out_last), 32'd0);
            check("mrst_err_len", N'(err_len), 32'd0);
            check("mrst_in_ready", N'(in_ready), 32'd0);
            rst_n = 1'b1;
        end
        repeat (6) @(posedge clk);
        #1;
        flush_cap();
        send_vec(32'h0000_8000);
        drain();
        check("post_rst_count", N'(cap_d.size()), 32'd20);
        for (int k = 0; k < cap_d.size(); k++) check("post_rst_data", cap_d[k], 32'h0000_8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
